// File: rtl/mnist_stream_pkg.sv
// Shared types and constants for the MNIST pixel streaming path.
package mnist_stream_pkg;

   localparam int unsigned FRAME_LEN = 784;
   localparam int unsigned PIX_W     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pacer_state_t;

   // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned PIX_CNT_W = cnt_w(FRAME_LEN + 1);

endpackage

// File: rtl/pixel_stream_pacer_rate_tick_gen.sv
// Clock-enable tick generator: one tick every DIV cycles while enabled.
// The counter is held at zero while disabled, so the first tick arrives
// DIV cycles after enable rises.
module rate_tick_gen #(
   parameter int unsigned DIV = 5
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic en_i,
   output logic tick_o
);
   import mnist_stream_pkg::*;

   localparam int unsigned   CW   = cnt_w(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] tick_cnt;

   // Free-running modulo-DIV counter, cleared whenever the enable drops.
   always_ff @(posedge clk_i) begin
      if (rstn_i || !en_i) begin
         tick_cnt <= '0;
      end else if (tick_cnt == LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   assign tick_o = en_i && (tick_cnt == LAST);

endmodule

// File: rtl/pixel_stream_pacer.sv
// Rate-paced pixel streamer: forwards one frame of FRAME_LEN pixels from a
// valid/ready source to a valid/ready sink at most one pixel per DIV cycles.
// rstn_i is a synchronous, active-high reset.
// Optional feature macro: PACER_UNDERRUN_CNT_EN adds underrun_cnt_o.
module pixel_stream_pacer #(
   parameter int unsigned DIV       = 5,
   parameter int unsigned DATA_W    = mnist_stream_pkg::PIX_W,
   parameter int unsigned FRAME_LEN = mnist_stream_pkg::FRAME_LEN
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              start_i,
   input  logic              s_valid_i,
   input  logic [DATA_W-1:0] s_data_i,
   output logic              s_ready_o,
   output logic              m_valid_o,
   output logic [DATA_W-1:0] m_data_o,
   output logic              m_last_o,
   input  logic              m_ready_i,
   output logic              busy_o,
   output logic              done_o
`ifdef PACER_UNDERRUN_CNT_EN
   ,
   output logic [15:0]       underrun_cnt_o
`endif
);
   import mnist_stream_pkg::*;

   localparam int unsigned PC_W = mnist_stream_pkg::cnt_w(FRAME_LEN + 1);

   pacer_state_t      state, next_state;
   logic              run;
   logic              tick;
   logic              tick_pend;
   logic              hold_valid;
   logic [DATA_W-1:0] hold_data;
   logic [PC_W-1:0]   pix_cnt;
   logic [PC_W-1:0]   load_idx;
   logic              m_hs;
   logic              load;
   logic              capture;

   assign run     = (state == RUN);
   assign m_hs    = m_valid_o && m_ready_i;
   assign load    = (tick || tick_pend) && hold_valid && (!m_valid_o || m_ready_i);
   assign capture = s_valid_i && s_ready_o;
   // pix_cnt counts completed handshakes; a pixel leaving in the same cycle
   // as a load shifts the loaded pixel's index by one.
   assign load_idx = pix_cnt + PC_W'(m_hs);

   rate_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .en_i   (run),
      .tick_o (tick)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rstn_i) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state decode: start only honoured in IDLE, frame ends on last handshake.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start_i) next_state = RUN;
         RUN:     if (m_hs && m_last_o) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // FSM-derived outputs; ready also asserts while the hold register is being
   // drained this cycle so that DIV=1 sustains one pixel per clock.
   always_comb begin
      busy_o    = run;
      done_o    = (state == DONE);
      s_ready_o = run && (!hold_valid || load);
   end

   // Hold register, tick credit and frame pixel counter.
   always_ff @(posedge clk_i) begin
      if (rstn_i) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
         tick_pend  <= 1'b0;
         pix_cnt    <= '0;
      end else if (!run) begin
         hold_valid <= 1'b0;
         tick_pend  <= 1'b0;
         pix_cnt    <= '0;
      end else begin
         if (capture) begin
            hold_data  <= s_data_i;
            hold_valid <= 1'b1;
         end else if (load) begin
            hold_valid <= 1'b0;
         end
         if (load)      tick_pend <= 1'b0;
         else if (tick) tick_pend <= 1'b1;
         if (m_hs) pix_cnt <= pix_cnt + 1'b1;
      end
   end

   // Output register: held stable until accepted, refilled without a bubble.
   always_ff @(posedge clk_i) begin
      if (rstn_i) begin
         m_valid_o <= 1'b0;
         m_data_o  <= '0;
         m_last_o  <= 1'b0;
      end else if (load) begin
         m_valid_o <= 1'b1;
         m_data_o  <= hold_data;
         m_last_o  <= (load_idx == PC_W'(FRAME_LEN - 1));
      end else if (m_hs) begin
         m_valid_o <= 1'b0;
         m_last_o  <= 1'b0;
      end
   end

`ifdef PACER_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;

   // Saturating count of ticks that found no pixel waiting.
   always_ff @(posedge clk_i) begin
      if (rstn_i) begin
         underrun_cnt <= '0;
      end else if (state == IDLE && start_i) begin
         underrun_cnt <= '0;
      end else if (tick && !hold_valid && underrun_cnt != '1) begin
         underrun_cnt <= underrun_cnt + 1'b1;
      end
   end

   assign underrun_cnt_o = underrun_cnt;
`endif

endmodule

// File: tb/tb_pixel_stream_pacer.sv
// Bench for pixel_stream_pacer: DIV=5 instance driven through directed
// scenarios, plus a DIV=1 instance for the sustained-rate regression.
module tb_pixel_stream_pacer;

   localparam int N   = 784;
   localparam int DW  = 16;
   localparam int DV  = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DIV=5 instance
   logic          rst, start, s_valid, s_ready, m_valid, m_last, m_ready, busy, done;
   logic [DW-1:0] s_data, m_data;
   // DIV=1 instance
   logic          f_rst, f_start, f_s_valid, f_s_ready, f_m_valid, f_m_last, f_m_ready, f_busy, f_done;
   logic [DW-1:0] f_s_data, f_m_data;
`ifdef PACER_UNDERRUN_CNT_EN
   logic [15:0]   underrun, f_underrun;
`endif

   pixel_stream_pacer #(.DIV(DV), .DATA_W(DW), .FRAME_LEN(N)) u_dut (
      .clk_i(clk), .rstn_i(rst), .start_i(start),
      .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
      .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last), .m_ready_i(m_ready),
      .busy_o(busy), .done_o(done)
`ifdef PACER_UNDERRUN_CNT_EN
      , .underrun_cnt_o(underrun)
`endif
   );

   pixel_stream_pacer #(.DIV(1), .DATA_W(DW), .FRAME_LEN(N)) u_fast (
      .clk_i(clk), .rstn_i(f_rst), .start_i(f_start),
      .s_valid_i(f_s_valid), .s_data_i(f_s_data), .s_ready_o(f_s_ready),
      .m_valid_o(f_m_valid), .m_data_o(f_m_data), .m_last_o(f_m_last), .m_ready_i(f_m_ready),
      .busy_o(f_busy), .done_o(f_done)
`ifdef PACER_UNDERRUN_CNT_EN
      , .underrun_cnt_o(f_underrun)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Frame-level model of the DIV=5 instance
   int          cyc = 0;
   bit          mdl_run = 0;
   bit          exp_done = 0;
   int          exp_idx = 0;
   int          src_idx = 0;
   int          gap = 0;
   int          gap_left = 0;
   bit          chk_spacing = 0;
   bit          chk_gaplat = 0;
   bit          prev_stall = 0;
   logic [DW-1:0] prev_data = '0;
   int          done_cnt = 0;
   int          last_hs_cyc = 0;
   int          first_valid_cyc = -1;
   int          cap_cyc = 0;
   logic [DW-1:0] seq5 [N];

   // One clock of the DIV=5 instance: drive source, compare against model, advance.
   task automatic cycle_slow();
      bit s_hs, m_hs, done_next;
      s_valid = (src_idx < N) && (gap_left == 0);
      s_data  = DW'(src_idx);
      #1;
      s_hs = s_valid && s_ready;
      m_hs = m_valid && m_ready;
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(mdl_run));
      if (!mdl_run) chk("idle_outs", {29'd0, m_valid, s_ready, m_last}, 32'd0);
      if (prev_stall) begin
         chk("stall_valid", 32'(m_valid), 32'd1);
         chk("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (gap > 0 && mdl_run && src_idx >= 2 && gap_left > 0 && gap_left <= gap - 1)
         chk("gap_ready", 32'(s_ready), 32'd1);
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_hs) begin
         chk("data", 32'(m_data), 32'(exp_idx));
         chk("last", 32'(m_last), 32'(exp_idx == N - 1));
         if (chk_spacing && exp_idx > 0) chk("spacing", 32'(cyc - last_hs_cyc), 32'(DV));
         if (chk_gaplat && exp_idx > 0) chk("gap_latency", 32'(cyc - cap_cyc), 32'd2);
         if (exp_idx < N) seq5[exp_idx] = m_data;
         last_hs_cyc = cyc;
      end
      if (s_hs) cap_cyc = cyc;
      done_next = m_hs && (exp_idx == N - 1);
      if (m_hs) exp_idx++;
      if (done_next) mdl_run = 0;
      if (start && !mdl_run && !exp_done) mdl_run = 1;
      exp_done = done_next;
      if (s_hs) begin
         src_idx++;
         gap_left = gap;
      end else if (gap_left > 0) begin
         gap_left--;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (done) done_cnt++;
      if (rst) begin
         mdl_run = 0; exp_done = 0; exp_idx = 0; src_idx = 0;
         gap_left = 0; prev_stall = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic begin_frame();
      src_idx = 0;
      exp_idx = 0;
      gap_left = 0;
      first_valid_cyc = -1;
      start = 1'b1;
      cycle_slow();
      start = 1'b0;
   endtask

   task automatic finish_frame(input string name, input int budget);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         cycle_slow();
         n++;
      end
      if (done_cnt == d0) chk({name, "_timeout"}, 32'd0, 32'd1);
      chk({name, "_count"}, 32'(exp_idx), 32'(N));
   endtask

   initial begin
      int start_cyc, d0, stall_left, n;
      bit stalled, pulsed;
      rst = 1; start = 0; s_valid = 0; s_data = '0; m_ready = 1;
      f_rst = 1; f_start = 0; f_s_valid = 0; f_s_data = '0; f_m_ready = 1;
      @(posedge clk);
      #1;
      // Reset state
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data",  32'(m_data),  32'd0);
      chk("rst_m_last",  32'(m_last),  32'd0);
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_done",    32'(done),    32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      cycle_slow();
      rst = 0;
      cycle_slow();

      // 1: always valid, always ready, exact pacing
      chk_spacing = 1;
      start_cyc = cyc;
      begin_frame();
      finish_frame("t1", 5000);
      chk("t1_first_latency", 32'(first_valid_cyc - start_cyc), 32'd6);
      chk("t1_last_hs_cycle", 32'(last_hs_cyc - start_cyc), 32'd3921);
      for (int i = 0; i < 5; i++) cycle_slow();
      chk("t1_done_once", 32'(done_cnt), 32'd1);
      chk_spacing = 0;

      // 2 + 4: 12-cycle backpressure at pixel 100, start pulsed at pixel 200
      d0 = done_cnt;
      begin_frame();
      stalled = 0; pulsed = 0; stall_left = 0; n = 0;
      while (mdl_run && n < 6000) begin
         if (!stalled && exp_idx == 100 && m_valid) begin
            stall_left = 12;
            stalled = 1;
         end
         if (stall_left == 1) chk("t2_stall_data", 32'(m_data), 32'd100);
         m_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         start = (!pulsed && exp_idx == 200);
         if (start) pulsed = 1;
         cycle_slow();
         n++;
      end
      m_ready = 1; start = 0;
      finish_frame("t2", 20);
      chk("t2_stalled", 32'(stalled), 32'd1);
      chk("t4_one_done", 32'(done_cnt - d0), 32'd1);

      // 3: upstream gaps of 20 cycles
      gap = 20; chk_gaplat = 1;
      begin_frame();
      finish_frame("t3", 20000);
      gap = 0; chk_gaplat = 0;
`ifdef PACER_UNDERRUN_CNT_EN
      chk("t3_underrun_pos", 32'(underrun > 16'd0), 32'd1);
`endif
      cycle_slow();

      // 5: reset at pixel 300, then a clean frame
      begin_frame();
      n = 0;
      while (exp_idx < 300 && n < 3000) begin
         cycle_slow();
         n++;
      end
      chk("t5_reached_300", 32'(exp_idx), 32'd300);
      d0 = done_cnt;
      rst = 1;
      cycle_slow();
      rst = 0;
      chk("t5_m_valid", 32'(m_valid), 32'd0);
      chk("t5_m_data",  32'(m_data),  32'd0);
      chk("t5_m_last",  32'(m_last),  32'd0);
      chk("t5_busy",    32'(busy),    32'd0);
      chk("t5_done",    32'(done),    32'd0);
      chk("t5_s_ready", 32'(s_ready), 32'd0);
      for (int i = 0; i < 20; i++) cycle_slow();
      chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
      begin_frame();
      finish_frame("t5", 5000);

      // 6: DIV=1 sustained rate, same data sequence as DIV=5 run
      begin
         int fsrc = 0, fidx = 0, fstart, ffirst = -1, fprev = 0, k = 0;
         f_rst = 0;
         @(posedge clk); #1; cyc++;
         fstart = cyc;
         f_start = 1;
         while (!f_done && k < 2000) begin
            f_s_valid = (fsrc < N);
            f_s_data  = DW'(fsrc);
            #1;
            if (f_m_valid && f_m_ready) begin
               chk("t6_data", 32'(f_m_data), 32'(seq5[fidx]));
               chk("t6_last", 32'(f_m_last), 32'(fidx == N - 1));
               if (fidx == 0) ffirst = cyc;
               else chk("t6_spacing", 32'(cyc - fprev), 32'd1);
               fprev = cyc;
               fidx++;
            end
            if (f_s_valid && f_s_ready) fsrc++;
            @(posedge clk); #1; cyc++; k++;
            f_start = 0;
         end
         if (!f_done) chk("t6_timeout", 32'd0, 32'd1);
         chk("t6_count", 32'(fidx), 32'(N));
         chk("t6_first_latency", 32'(ffirst - fstart), 32'd3);
         chk("t6_sustained", 32'(fprev - ffirst), 32'(N - 1));
         chk("t6_seq_first", 32'(seq5[0]), 32'd0);
         chk("t6_seq_last", 32'(seq5[N-1]), 32'd783);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
